trap_unit: RTL and testbench
============================

Name: trap_unit

Overview:
- Commit-stage trap controller for the RV64 pipeline.
- Watches the instruction at commit for exceptions, interrupts and mret, drains and flushes the pipeline, then issues a one-cycle exception write (enable, mret, mstatus, mcause, mepc) to the CSR file.
- Redirects fetch to the trap vector or to mepc.
- Sits between writeback/commit and the CSR file and fetch redirect logic.

Parameters:
XLEN, 64, data/PC width.
MTVEC_VECTORED_EN, 1, when 1, honour mtvec.MODE=1 (vectored) for interrupts; when 0, always direct.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
commit_valid  input  1  instruction at commit this cycle
commit_pc  input  XLEN  PC of the committing instruction
commit_ecall  input  1  committing instruction is ecall
commit_mret  input  1  committing instruction is mret
commit_illegal  input  1  illegal instruction
commit_imisalign  input  1  instruction address misaligned
commit_lmisalign  input  1  load address misaligned
commit_smisalign  input  1  store address misaligned
dmem_busy  input  1  outstanding data-memory transaction
mstatus_in  input  XLEN  current mstatus from the CSR file (valid while excep_readstatus=1)
mtvec_in  input  XLEN  current mtvec
mepc_in  input  XLEN  current mepc
mie_in  input  XLEN  current mie
mip_in  input  XLEN  current mip
excep_readstatus  output  1  requests mstatus_in
excep_enable  output  1  one-cycle CSR exception write strobe
excep_mret  output  1  write is an mret (mcause/mepc untouched)
excep_mstatus  output  XLEN  new mstatus
excep_mcause  output  XLEN  trap cause
excep_mepc  output  XLEN  trapping PC
flush  output  1  kill all younger in-flight instructions
stall  output  1  freeze commit and upstream stages
redirect_valid  output  1  fetch redirect request
redirect_pc  output  XLEN  redirect target
redirect_ready  input  1  fetch accepts redirect

Behaviour:
- Reset (async): state=IDLE; every output 0; latched registers 0.
- FSM states: IDLE, DRAIN, WRITE, REDIRECT.
- IDLE:
  - Event = commit_valid & (pending_irq | any commit_* flag).
  - pending_irq = mstatus_in[3] & |(mie_in & mip_in & {bit11, bit7, bit3}).
  - excep_readstatus=1 in IDLE and DRAIN.
  - On event: latch cause, pc, mret flag and mstatus_in; go to DRAIN. The committing instruction does not retire.
- Cause priority, highest first:
  - MEI (2^63|11), MSI (2^63|3), MTI (2^63|7)
  - imisalign (0), illegal (2), ecall (11), lmisalign (4), smisalign (6)
  - mret (no cause)
  - mret together with any exception is treated as that exception.
- DRAIN: flush=1, stall=1. Stay in DRAIN while dmem_busy=1; when it is 0, go to WRITE. Minimum one cycle in DRAIN.
- WRITE: exactly one cycle with excep_enable=1, stall=1. Next state is REDIRECT.
  - Trap mstatus: MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11; other bits unchanged. excep_mcause=cause, excep_mepc=latched pc, excep_mret=0.
  - mret mstatus: MIE<=MPIE, MPIE<=1, MPP<=2'b00. excep_mret=1; mcause/mepc outputs are 0.
- REDIRECT: redirect_valid=1, stall=1, redirect_pc held stable until redirect_ready; on the cycle with ready=1, go to IDLE.
  - Trap target: {mtvec_in[63:2],2'b00}.
  - If mtvec_in[1:0]==1, MTVEC_VECTORED_EN=1 and the cause is an interrupt, target is base + 4*cause[5:0].
  - mret target: mepc_in sampled in REDIRECT, which is after the CSR write has landed.
- Latency from an accepted event to redirect_valid is 3 cycles when dmem_busy=0 and the redirect is accepted immediately.
- All commit_* and interrupt inputs are ignored outside IDLE. A new interrupt that becomes pending during a trap is taken on the first qualifying commit after IDLE.
- A trap handler's first instruction sees MIE=0, so there is no re-entry loop.
- Reset asserted in any state returns to IDLE immediately and drops every output. No partial CSR write is issued after reset.

Test Plan:
- ecall at pc=0x8000_0010, mstatus=0x8, mtvec=0x8000_1000 -> excep_enable pulse with mcause=11, mepc=0x8000_0010, mstatus=0x1880; redirect_pc=0x8000_1000 three cycles after commit.
- mret with mstatus=0x1880, mepc=0x8000_0014 -> excep_mret=1, mstatus=0x0088, redirect_pc=0x8000_0014.
- MTI pending (mie=mip=0x80, MIE=1), mtvec=0x8000_1001, concurrent illegal commit -> mcause=0x8000_0000_0000_0007, redirect_pc=0x8000_101C.
- Same MTI setup but MIE=0 -> no event; ordinary commit, stall=0.
- dmem_busy held for 4 cycles in DRAIN -> flush held 4+ cycles, excep_enable only after busy drops; redirect_ready low for 2 cycles -> redirect_pc stable, returns to IDLE on ready.
- Reset asserted in WRITE -> outputs 0 that cycle, state IDLE, no redirect follows.

Source files
------------

// File: rtl/trap_unit_if.sv
// rtl/trap_unit_if.sv - commit/CSR/redirect bundle between the pipeline and trap_unit
//
// Purpose: groups every non-clock/reset signal of trap_unit.
//   commit_*        : instruction at commit and its exception flags
//   dmem_busy       : outstanding data-memory transaction
//   *_in            : current CSR values (mstatus, mtvec, mepc, mie, mip)
//   excep_*         : one-cycle CSR exception write and mstatus read request
//   flush / stall   : pipeline control
//   redirect_*      : fetch redirect handshake
// modport slave  : the trap unit side
// modport master : the pipeline / CSR file / fetch side
interface trap_unit_if #(parameter int XLEN = 64);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_ecall;
  logic            commit_mret;
  logic            commit_illegal;
  logic            commit_imisalign;
  logic            commit_lmisalign;
  logic            commit_smisalign;
  logic            dmem_busy;
  logic [XLEN-1:0] mstatus_in;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic [XLEN-1:0] mie_in;
  logic [XLEN-1:0] mip_in;
  logic            excep_readstatus;
  logic            excep_enable;
  logic            excep_mret;
  logic [XLEN-1:0] excep_mstatus;
  logic [XLEN-1:0] excep_mcause;
  logic [XLEN-1:0] excep_mepc;
  logic            flush;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport slave (
    input  commit_valid, commit_pc, commit_ecall, commit_mret, commit_illegal,
           commit_imisalign, commit_lmisalign, commit_smisalign, dmem_busy,
           mstatus_in, mtvec_in, mepc_in, mie_in, mip_in, redirect_ready,
    output excep_readstatus, excep_enable, excep_mret, excep_mstatus,
           excep_mcause, excep_mepc, flush, stall, redirect_valid, redirect_pc
  );

  modport master (
    output commit_valid, commit_pc, commit_ecall, commit_mret, commit_illegal,
           commit_imisalign, commit_lmisalign, commit_smisalign, dmem_busy,
           mstatus_in, mtvec_in, mepc_in, mie_in, mip_in, redirect_ready,
    input  excep_readstatus, excep_enable, excep_mret, excep_mstatus,
           excep_mcause, excep_mepc, flush, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_unit.sv
// rtl/trap_unit.sv - commit-stage trap controller (exceptions, interrupts, mret)
//
// Purpose: detects a trap or mret at commit, drains and flushes the pipeline,
// issues one CSR exception write, then redirects fetch.
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-high reset
//   io_bus  : trap_unit_if.slave (commit inputs, CSR values, CSR write,
//             flush/stall, fetch redirect handshake)
module trap_unit #(
  parameter int XLEN              = 64,
  parameter bit MTVEC_VECTORED_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  trap_unit_if.slave io_bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, REDIRECT} state_t;

  localparam logic [XLEN-1:0] IRQ_FLAG    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_MEI       = IRQ_FLAG | XLEN'(11);
  localparam logic [XLEN-1:0] C_MSI       = IRQ_FLAG | XLEN'(3);
  localparam logic [XLEN-1:0] C_MTI       = IRQ_FLAG | XLEN'(7);
  localparam logic [XLEN-1:0] C_IMISALIGN = XLEN'(0);
  localparam logic [XLEN-1:0] C_ILLEGAL   = XLEN'(2);
  localparam logic [XLEN-1:0] C_ECALL     = XLEN'(11);
  localparam logic [XLEN-1:0] C_LMISALIGN = XLEN'(4);
  localparam logic [XLEN-1:0] C_SMISALIGN = XLEN'(6);

  state_t          r_state;
  logic            r_readstatus;
  logic            r_excep_enable;
  logic            r_excep_mret;
  logic [XLEN-1:0] r_excep_mstatus;
  logic [XLEN-1:0] r_excep_mcause;
  logic [XLEN-1:0] r_excep_mepc;
  logic            r_flush;
  logic            r_stall;
  logic            r_redirect_valid;

  // Event context captured at commit.
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mstatus;
  logic            r_is_mret;

  logic [XLEN-1:0] w_pend;
  logic            w_mei, w_msi, w_mti;
  logic            w_any_exc;
  logic            w_event;
  logic            w_take_mret;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_trap_mstatus;
  logic [XLEN-1:0] w_mret_mstatus;
  logic [XLEN-1:0] w_base;
  logic            w_vectored;
  logic [XLEN-1:0] w_trap_target;

  always_comb begin
    w_pend    = io_bus.mie_in & io_bus.mip_in;
    w_mei     = io_bus.mstatus_in[3] & w_pend[11];
    w_msi     = io_bus.mstatus_in[3] & w_pend[3];
    w_mti     = io_bus.mstatus_in[3] & w_pend[7];
    w_any_exc = io_bus.commit_ecall | io_bus.commit_illegal | io_bus.commit_imisalign |
                io_bus.commit_lmisalign | io_bus.commit_smisalign;
    w_event   = io_bus.commit_valid & (w_mei | w_msi | w_mti | w_any_exc | io_bus.commit_mret);
    // mret only stands alone; any concurrent exception or interrupt wins.
    w_take_mret = io_bus.commit_mret & ~(w_mei | w_msi | w_mti | w_any_exc);

    w_cause = '0;
    if      (w_mei)                   w_cause = C_MEI;
    else if (w_msi)                   w_cause = C_MSI;
    else if (w_mti)                   w_cause = C_MTI;
    else if (io_bus.commit_imisalign) w_cause = C_IMISALIGN;
    else if (io_bus.commit_illegal)   w_cause = C_ILLEGAL;
    else if (io_bus.commit_ecall)     w_cause = C_ECALL;
    else if (io_bus.commit_lmisalign) w_cause = C_LMISALIGN;
    else if (io_bus.commit_smisalign) w_cause = C_SMISALIGN;
  end

  always_comb begin
    w_trap_mstatus         = r_mstatus;
    w_trap_mstatus[7]      = r_mstatus[3];
    w_trap_mstatus[3]      = 1'b0;
    w_trap_mstatus[12:11]  = 2'b11;

    w_mret_mstatus         = r_mstatus;
    w_mret_mstatus[3]      = r_mstatus[7];
    w_mret_mstatus[7]      = 1'b1;
    w_mret_mstatus[12:11]  = 2'b00;
  end

  always_comb begin
    w_base        = {io_bus.mtvec_in[XLEN-1:2], 2'b00};
    w_vectored    = MTVEC_VECTORED_EN && (io_bus.mtvec_in[1:0] == 2'b01) && r_cause[XLEN-1];
    w_trap_target = w_vectored ? (w_base + XLEN'({r_cause[5:0], 2'b00})) : w_base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_readstatus     <= 1'b0;
      r_excep_enable   <= 1'b0;
      r_excep_mret     <= 1'b0;
      r_excep_mstatus  <= '0;
      r_excep_mcause   <= '0;
      r_excep_mepc     <= '0;
      r_flush          <= 1'b0;
      r_stall          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_cause          <= '0;
      r_pc             <= '0;
      r_mstatus        <= '0;
      r_is_mret        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_readstatus <= 1'b1;
          if (w_event) begin
            r_cause   <= w_cause;
            r_pc      <= io_bus.commit_pc;
            r_mstatus <= io_bus.mstatus_in;
            r_is_mret <= w_take_mret;
            r_flush   <= 1'b1;
            r_stall   <= 1'b1;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!io_bus.dmem_busy) begin
            r_flush         <= 1'b0;
            r_readstatus    <= 1'b0;
            r_excep_enable  <= 1'b1;
            r_excep_mret    <= r_is_mret;
            r_excep_mstatus <= r_is_mret ? w_mret_mstatus : w_trap_mstatus;
            r_excep_mcause  <= r_is_mret ? '0 : r_cause;
            r_excep_mepc    <= r_is_mret ? '0 : r_pc;
            r_state         <= WRITE;
          end
        end
        WRITE: begin
          r_excep_enable   <= 1'b0;
          r_excep_mret     <= 1'b0;
          r_excep_mstatus  <= '0;
          r_excep_mcause   <= '0;
          r_excep_mepc     <= '0;
          r_redirect_valid <= 1'b1;
          r_state          <= REDIRECT;
        end
        REDIRECT: begin
          if (io_bus.redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_stall          <= 1'b0;
            r_readstatus     <= 1'b1;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.excep_readstatus = r_readstatus;
  assign io_bus.excep_enable     = r_excep_enable;
  assign io_bus.excep_mret       = r_excep_mret;
  assign io_bus.excep_mstatus    = r_excep_mstatus;
  assign io_bus.excep_mcause     = r_excep_mcause;
  assign io_bus.excep_mepc       = r_excep_mepc;
  assign io_bus.flush            = r_flush;
  assign io_bus.stall            = r_stall;
  assign io_bus.redirect_valid   = r_redirect_valid;
  // Target is taken from the live CSR values during REDIRECT so an mret sees
  // mepc after the CSR write has landed; CSRs are frozen while stall holds.
  assign io_bus.redirect_pc      = r_redirect_valid ? (r_is_mret ? io_bus.mepc_in : w_trap_target) : '0;

endmodule

// File: tb/tb_trap_unit.sv
// tb/tb_trap_unit.sv - randomized self-checking bench for trap_unit
module tb_trap_unit;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;

  trap_unit_if #(.XLEN(XLEN)) bus();

  trap_unit #(.XLEN(XLEN), .MTVEC_VECTORED_EN(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ev;
    logic        is_mret;
    logic [63:0] cause;
    logic [63:0] mstatus;
    logic [63:0] mepc;
    logic [63:0] target;
  } pred_t;

  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  logic  cmp_on  = 1'b0;
  logic  rs_ok   = 1'b0;
  logic  sched_on = 1'b0;
  int    s_t0, s_b, s_r;
  pred_t s_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: what a commit should produce, from the architectural rules.
  // fl = {smisalign, lmisalign, imisalign, illegal, mret, ecall}
  function automatic pred_t predict(input logic cv, input logic [63:0] pc, input logic [5:0] fl,
                                    input logic [63:0] mst, input logic [63:0] mtv,
                                    input logic [63:0] mep, input logic [63:0] mie,
                                    input logic [63:0] mip);
    pred_t       p;
    logic [63:0] pend;
    logic        hit   [8];
    logic [63:0] codes [8];
    p    = '0;
    pend = mie & mip;
    hit[0] = mst[3] & pend[11]; codes[0] = 64'h8000_0000_0000_000B;
    hit[1] = mst[3] & pend[3];  codes[1] = 64'h8000_0000_0000_0003;
    hit[2] = mst[3] & pend[7];  codes[2] = 64'h8000_0000_0000_0007;
    hit[3] = fl[3];             codes[3] = 64'd0;
    hit[4] = fl[2];             codes[4] = 64'd2;
    hit[5] = fl[0];             codes[5] = 64'd11;
    hit[6] = fl[4];             codes[6] = 64'd4;
    hit[7] = fl[5];             codes[7] = 64'd6;
    if (!cv) return p;
    for (int i = 7; i >= 0; i--) begin
      if (hit[i]) begin
        p.ev    = 1'b1;
        p.cause = codes[i];
      end
    end
    if (p.ev) begin
      p.mstatus = (mst & ~64'h1888) | 64'h1800 | (mst[3] ? 64'h80 : 64'h0);
      p.mepc    = pc;
      p.target  = mtv & ~64'h3;
      if (p.cause[63] && (mtv % 4) == 1) p.target = p.target + 4 * (p.cause % 64);
    end else if (fl[1]) begin
      p.ev      = 1'b1;
      p.is_mret = 1'b1;
      p.mstatus = (mst & ~64'h1888) | 64'h80 | (mst[7] ? 64'h8 : 64'h0);
      p.target  = mep;
    end
    return p;
  endfunction

  // Expected timeline of an accepted event at cycle t0 with b busy cycles and
  // r not-ready cycles: drain t0+1..t0+1+b, write t0+2+b, redirect t0+3+b..t0+3+b+r.
  always @(negedge clk) begin : cmp_blk
    int   d;
    logic e_fl, e_st, e_en, e_rv, e_rs;
    if (!reset && cmp_on) begin
      e_fl = 1'b0; e_st = 1'b0; e_en = 1'b0; e_rv = 1'b0; e_rs = rs_ok;
      d = sched_on ? (cyc - s_t0) : 0;
      if (sched_on && d >= 1 && d <= 1 + s_b) begin
        e_fl = 1'b1; e_st = 1'b1;
      end else if (sched_on && d == 2 + s_b) begin
        e_st = 1'b1; e_en = 1'b1; e_rs = 1'b0;
      end else if (sched_on && d >= 3 + s_b && d <= 3 + s_b + s_r) begin
        e_st = 1'b1; e_rv = 1'b1; e_rs = 1'b0;
      end
      chk1("flush", bus.flush, e_fl);
      chk1("stall", bus.stall, e_st);
      chk1("excep_enable", bus.excep_enable, e_en);
      chk1("redirect_valid", bus.redirect_valid, e_rv);
      chk1("excep_readstatus", bus.excep_readstatus, e_rs);
      if (e_en) begin
        chk1("excep_mret", bus.excep_mret, s_p.is_mret);
        chk64("excep_mstatus", bus.excep_mstatus, s_p.mstatus);
        chk64("excep_mcause", bus.excep_mcause, s_p.cause);
        chk64("excep_mepc", bus.excep_mepc, s_p.mepc);
      end
      if (e_rv) chk64("redirect_pc", bus.redirect_pc, s_p.target);
    end
  end

  task automatic run_txn(input logic cv, input logic [63:0] pc, input logic [5:0] fl,
                         input logic [63:0] mst, input logic [63:0] mtv, input logic [63:0] mep,
                         input logic [63:0] mie, input logic [63:0] mip,
                         input int b, input int r, input int abort_k);
    pred_t p;
    @(posedge clk); #1;
    sched_on = 1'b0;
    bus.commit_valid = cv;
    bus.commit_pc    = pc;
    {bus.commit_smisalign, bus.commit_lmisalign, bus.commit_imisalign,
     bus.commit_illegal, bus.commit_mret, bus.commit_ecall} = fl;
    bus.mstatus_in     = mst;
    bus.mtvec_in       = mtv;
    bus.mepc_in        = mep;
    bus.mie_in         = mie;
    bus.mip_in         = mip;
    bus.dmem_busy      = 1'($urandom_range(0, 1));
    bus.redirect_ready = 1'($urandom_range(0, 1));
    p = predict(cv, pc, fl, mst, mtv, mep, mie, mip);
    if (p.ev) begin
      s_p = p; s_t0 = cyc; s_b = b; s_r = r; sched_on = 1'b1;
      for (int k = 1; k <= 3 + b + r; k++) begin
        @(posedge clk); #1;
        if (k == abort_k) begin
          reset = 1'b1; sched_on = 1'b0; rs_ok = 1'b0;
          #1;
          chk1("rst_excep_enable", bus.excep_enable, 1'b0);
          chk1("rst_flush", bus.flush, 1'b0);
          chk1("rst_stall", bus.stall, 1'b0);
          chk1("rst_redirect_valid", bus.redirect_valid, 1'b0);
          chk1("rst_readstatus", bus.excep_readstatus, 1'b0);
          return;
        end
        // Anything on the commit/interrupt inputs must be ignored mid-trap.
        bus.commit_valid = 1'($urandom_range(0, 1));
        bus.commit_pc    = {$urandom, $urandom};
        {bus.commit_smisalign, bus.commit_lmisalign, bus.commit_imisalign,
         bus.commit_illegal, bus.commit_mret, bus.commit_ecall} = 6'($urandom);
        bus.mstatus_in = {$urandom, $urandom};
        bus.mie_in     = {$urandom, $urandom};
        bus.mip_in     = {$urandom, $urandom};
        bus.dmem_busy  = (k <= b) ? 1'b1 : (k == b + 1) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.redirect_ready = (k == 3 + b + r) ? 1'b1 :
                             (k < 3 + b) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  initial begin
    pred_t p;
    reset = 1'b1;
    bus.commit_valid = 1'b0; bus.commit_pc = '0;
    bus.commit_ecall = 1'b0; bus.commit_mret = 1'b0; bus.commit_illegal = 1'b0;
    bus.commit_imisalign = 1'b0; bus.commit_lmisalign = 1'b0; bus.commit_smisalign = 1'b0;
    bus.dmem_busy = 1'b0; bus.redirect_ready = 1'b0;
    bus.mstatus_in = '0; bus.mtvec_in = '0; bus.mepc_in = '0; bus.mie_in = '0; bus.mip_in = '0;
    #1;
    chk1("reset_excep_enable", bus.excep_enable, 1'b0);
    chk1("reset_flush", bus.flush, 1'b0);
    chk1("reset_stall", bus.stall, 1'b0);
    chk1("reset_redirect_valid", bus.redirect_valid, 1'b0);
    chk1("reset_readstatus", bus.excep_readstatus, 1'b0);
    chk64("reset_redirect_pc", bus.redirect_pc, 64'h0);
    chk64("reset_excep_mstatus", bus.excep_mstatus, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    cmp_on = 1'b1;
    @(posedge clk); #1;
    rs_ok = 1'b1;

    // Hand-computed pins on the reference model.
    p = predict(1'b1, 64'h8000_0010, 6'b000001, 64'h8, 64'h8000_1000, 64'h0, 64'h0, 64'h0);
    chk64("pin_ecall_cause", p.cause, 64'd11);
    chk64("pin_ecall_mstatus", p.mstatus, 64'h1880);
    chk64("pin_ecall_target", p.target, 64'h8000_1000);
    p = predict(1'b1, 64'h0, 6'b000010, 64'h1880, 64'h0, 64'h8000_0014, 64'h0, 64'h0);
    chk64("pin_mret_mstatus", p.mstatus, 64'h0088);
    chk64("pin_mret_target", p.target, 64'h8000_0014);
    p = predict(1'b1, 64'h0, 6'b000100, 64'h8, 64'h8000_1001, 64'h0, 64'h80, 64'h80);
    chk64("pin_mti_cause", p.cause, 64'h8000_0000_0000_0007);
    chk64("pin_mti_target", p.target, 64'h8000_101C);
    p = predict(1'b1, 64'h0, 6'b000000, 64'h0, 64'h8000_1001, 64'h0, 64'h80, 64'h80);
    chk1("pin_mti_masked", p.ev, 1'b0);

    // Directed scenarios.
    run_txn(1'b1, 64'h8000_0010, 6'b000001, 64'h8, 64'h8000_1000, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    run_txn(1'b1, 64'h8000_0040, 6'b000010, 64'h1880, 64'h8000_1000, 64'h8000_0014, 64'h0, 64'h0, 0, 0, 0);
    run_txn(1'b1, 64'h8000_0050, 6'b000100, 64'h8, 64'h8000_1001, 64'h0, 64'h80, 64'h80, 0, 0, 0);
    run_txn(1'b1, 64'h8000_0050, 6'b000000, 64'h0, 64'h8000_1001, 64'h0, 64'h80, 64'h80, 0, 0, 0);
    run_txn(1'b1, 64'h8000_0060, 6'b000001, 64'h8, 64'h8000_1000, 64'h0, 64'h0, 64'h0, 4, 2, 0);

    // Reset landing in the write cycle: nothing may follow it.
    run_txn(1'b1, 64'h8000_0070, 6'b000001, 64'h8, 64'h8000_1000, 64'h0, 64'h0, 64'h0, 0, 0, 2);
    @(posedge clk); #1;
    bus.commit_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    rs_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      run_txn(1'b0, 64'h0, 6'b0, 64'h0, 64'h8000_1000, 64'h0, 64'h0, 64'h0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      logic [5:0]  fl;
      logic [63:0] pc, mst, mtv, mep, mie, mip;
      logic        cv;
      fl = '0;
      for (int b = 0; b < 6; b++) fl[b] = ($urandom_range(0, 7) == 0);
      pc  = {$urandom, $urandom} & ~64'h3;
      mst = {$urandom, $urandom};
      mtv = {$urandom, $urandom};
      mep = {$urandom, $urandom} & ~64'h3;
      mie = {$urandom, $urandom} & 64'h888;
      mip = {$urandom, $urandom} & 64'h888;
      cv  = ($urandom_range(0, 3) != 0);
      run_txn(cv, pc, fl, mst, mtv, mep, mie, mip,
              $urandom_range(0, 4), $urandom_range(0, 3), 0);
    end

    @(posedge clk); #1;
    sched_on = 1'b0;
    bus.commit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
